seg_capture: RTL and testbench
==============================

Name: seg_capture

Overview:
- Receive-side monitor for the multiplexed 4-digit 7-segment bus: samples the active-low anode and cathode lines and reconstructs the digit values being shown.
- Inverse of the digit-to-cathode encoder; sits beside the display driver, on the same clock.
- Used for on-chip self-check and to give the bench a readable scoreboard of displayed values.
- Rejects transient patterns by requiring stability before capture; reports each full 4-digit frame.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of {an, cathode} required before capture; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- an  input  4  anode enables, active-low; an[i]=0 selects digit i
- cathode  input  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}
- digits  output  16  last complete frame; digits[4i+3:4i] = digit i
- frame_valid  output  1  one-cycle pulse when digits updates
- digit_seen  output  4  digit slots captured in the current, incomplete frame
- err_pattern  output  1  one-cycle pulse: captured cathode matched no legal pattern
- err_anode  output  1  one-cycle pulse: more than one anode low for a full stable window

Behaviour:
- Reset: sampled by clk while rst_n=0. All outputs, registers, counters and frame slots clear to 0; state WAIT; sample register loads 4'hF / 7'h7F (blank).
- Input stage: {an, cathode} are registered once every cycle. All further logic uses the registered sample (smp) and the previous sample (prev).
- Stability counter cnt (8 bit):
  - smp != prev -> cnt=0 and state=WAIT.
  - smp == prev -> cnt increments, saturating at STABLE_CYCLES.
- State WAIT: on the cycle cnt reaches STABLE_CYCLES-1 with smp == prev, the window is stable. Evaluate the anode pattern:
  - Exactly one bit low (index i): capture.
  - All high: blank bus; no action.
  - More than one low: pulse err_anode, no capture.
  - In every case go to HOLD.
- State HOLD: no further action until smp changes, which returns the state to WAIT. Each stable window therefore produces at most one event.
- Capture of digit i:
  - Decoded nibble goes to slot[i] and digit_seen[i] is set.
  - Capturing the same index twice in one frame overwrites the slot.
- Decode table (cathode to nibble):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 decodes to 4'hF (blank).
  - Any other pattern decodes to 4'hE and pulses err_pattern in the capture cycle. The slot is still written.
- Frame completion: if a capture makes digit_seen == 4'b1111, then on the same edge:
  - digits loads all four slots, including the new value.
  - frame_valid pulses for one cycle.
  - digit_seen clears to 0.
- Latency: an input held from edge k is first sampled at edge k. The capture and all pulses take effect at edge k+STABLE_CYCLES. Outputs are registered.
- Simultaneous events: an err_pattern pulse and a frame_valid pulse may coincide. digits is never modified except at frame completion.
- Reset mid-frame discards the partial slots and digit_seen. An input change during the stability count restarts the count.
- Counter saturation means arbitrarily long holds never wrap and never re-trigger.

Decomposition:
- Shared package seg_pkg:
  - Cathode constants SEG_0..SEG_9 and SEG_BLANK (shared with the encoder).
  - Nibble codes DIG_BLANK=4'hF and DIG_ERR=4'hE.
  - State encoding WAIT/HOLD.
- One combinational sub-module, seg_decode: cathode[6:0] -> {nibble[3:0], illegal}. It is the exact inverse of the encoder table.

Test Plan:
- Stable single digit: reset, then hold an=1110, cathode=0100100 for 4 cycles -> digit_seen=0001 at edge 4, no pulses. Hold 100 more cycles -> no further events.
- Full frame: scan an=1110/1101/1011/0111 with digits 1,2,3,4, 8 cycles each -> frame_valid pulses once at the fourth capture, digits=16'h4321, digit_seen returns to 0.
- Glitch rejection: toggle cathode every 3 cycles with STABLE_CYCLES=4 -> no capture and no pulse. A 4-cycle hold then captures once.
- Illegal inputs:
  - cathode=0101010 on an=1011 -> err_pattern pulse, slot 2=4'hE.
  - an=1100 held 10 cycles -> exactly one err_anode pulse, digit_seen unchanged.
  - an=1111 -> nothing.
- Blank and reset: blank pattern 1111111 on digit 0 completes a frame with digits[3:0]=4'hF. Asserting rst_n=0 after 3 captures clears digit_seen and digits to 0 on the next edge.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: cathode patterns (active-low {g,f,e,d,c,b,a}),
// nibble codes for blank/illegal digits, and the capture FSM state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic {
    WAIT = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Cathode-to-nibble decoder: exact inverse of the digit encoder table.
// Unknown patterns map to DIG_ERR and raise illegal.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] cathode,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Table lookup; anything not produced by the encoder is flagged
  always_comb begin
    nibble  = DIG_ERR;
    illegal = 1'b0;
    case (cathode)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: nibble = DIG_BLANK;
      default: begin
        nibble  = DIG_ERR;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Receive-side monitor for the multiplexed 4-digit 7-segment bus. Waits for
// {an, cathode} to be stable for STABLE_CYCLES samples, captures the selected
// digit once per stable window and reports each complete 4-digit frame.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  cathode,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  digit_seen,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  CNT_FIRE = 8'(STABLE_CYCLES - 1);
  localparam logic [10:0] SMP_IDLE = {4'hF, SEG_BLANK};

  logic [10:0] smp;
  logic [10:0] prev;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  state_t      state;
  logic [3:0]  slot [4];
  logic [3:0]  nibble;
  logic        illegal;
  logic [2:0]  low_cnt;
  logic [1:0]  low_idx;
  logic [3:0]  seen_nxt;
  logic [15:0] frame_nxt;

  seg_decode u_decode (
    .cathode (smp[6:0]),
    .nibble  (nibble),
    .illegal (illegal)
  );

  // Count low anodes in the registered sample and remember which one is low
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!smp[7 + i]) begin
        low_cnt = low_cnt + 3'd1;
        low_idx = 2'(i);
      end
    end
  end

  // Saturating stability count and the slot/frame values a capture would produce
  always_comb begin
    cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
    seen_nxt  = digit_seen | (4'b0001 << low_idx);
    frame_nxt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      frame_nxt[4*i +: 4] = (2'(i) == low_idx) ? nibble : slot[i];
    end
  end

  // Input sampling, stability tracking, WAIT/HOLD FSM, capture and frame assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp         <= SMP_IDLE;
      prev        <= SMP_IDLE;
      cnt         <= '0;
      state       <= WAIT;
      digits      <= '0;
      frame_valid <= 1'b0;
      digit_seen  <= '0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        slot[i] <= '0;
      end
    end else begin
      smp         <= {an, cathode};
      prev        <= smp;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      if (smp != prev) begin
        cnt   <= '0;
        state <= WAIT;
      end else begin
        cnt <= cnt_nxt;
        // cnt_nxt hits CNT_FIRE exactly once per window, so HOLD only guards re-entry
        if ((state == WAIT) && (cnt_nxt == CNT_FIRE)) begin
          state <= HOLD;
          if (low_cnt == 3'd1) begin
            slot[low_idx] <= nibble;
            err_pattern   <= illegal;
            if (seen_nxt == 4'hF) begin
              digits      <= frame_nxt;
              frame_valid <= 1'b1;
              digit_seen  <= '0;
            end else begin
              digit_seen  <= seen_nxt;
            end
          end else if (low_cnt > 3'd1) begin
            err_anode <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scenarios plus randomized bus
// traffic, all checked against a run-length based reference model.
module tb_seg_capture;

  localparam int S = 4;
  localparam logic [6:0] PATS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [6:0]  cathode = 7'h7F;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  digit_seen;
  logic        err_pattern;
  logic        err_anode;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] m_digits;
  logic        m_fv, m_ep, m_ea;
  logic [3:0]  m_seen;
  logic [3:0]  m_slot [4];
  logic [10:0] last;
  int          run;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .cathode     (cathode),
    .digits      (digits),
    .frame_valid (frame_valid),
    .digit_seen  (digit_seen),
    .err_pattern (err_pattern),
    .err_anode   (err_anode)
  );

  always #5 clk = ~clk;

  wire [22:0] obs  = {digits, frame_valid, digit_seen, err_pattern, err_anode};
  wire [22:0] expv = {m_digits, m_fv, m_seen, m_ep, m_ea};

  // Returns {illegal, nibble} from the display table
  function automatic logic [4:0] ref_decode(input logic [6:0] c);
    for (int d = 0; d < 10; d++) begin
      if (c == PATS[d]) return {1'b0, 4'(d)};
    end
    if (c == 7'h7F) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  // One clock edge; the model decides from how long the bus value has been held
  task automatic tick();
    int zeros;
    int idx;
    logic [4:0] dec;
    @(posedge clk);
    m_fv = 1'b0;
    m_ep = 1'b0;
    m_ea = 1'b0;
    if (!rst_n) begin
      m_digits = '0;
      m_seen   = '0;
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      last = {4'hF, 7'h7F};
      run  = S + 1;
    end else begin
      if (run == S) begin
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) begin
          if (!last[7 + i]) begin
            zeros++;
            idx = i;
          end
        end
        if (zeros == 1) begin
          dec = ref_decode(last[6:0]);
          m_slot[idx] = dec[3:0];
          m_ep = dec[4];
          m_seen[idx] = 1'b1;
          if (m_seen == 4'hF) begin
            m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_fv = 1'b1;
            m_seen = '0;
          end
        end else if (zeros > 1) begin
          m_ea = 1'b1;
        end
      end
      if ({an, cathode} == last) begin
        if (run <= S) run++;
      end else begin
        last = {an, cathode};
        run = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an = 4'b0000;
    cathode = 7'h55;
    repeat (3) begin
      tick();
      vectors++;
      if (obs !== 23'd0) begin
        miscompares++;
        $display("FAIL reset_state: got %h want %h", obs, 23'd0);
      end
    end
    rst_n = 1'b1;
    an = 4'hF;
    cathode = 7'h7F;
  endtask

  task automatic test_single_digit();
    int pulses = 0;
    an = 4'b1110;
    cathode = PATS[2];
    for (int c = 1; c <= S + 101; c++) begin
      tick();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL single_model c=%0d: got %h want %h", c, obs, expv);
      end
      if (c == S) begin
        vectors++;
        if (digit_seen !== 4'b0000) begin
          miscompares++;
          $display("FAIL single_early: got %b want 0000", digit_seen);
        end
      end
      if (c == S + 1) begin
        vectors++;
        if (digit_seen !== 4'b0001) begin
          miscompares++;
          $display("FAIL single_capture: got %b want 0001", digit_seen);
        end
      end
      pulses += int'(frame_valid) + int'(err_pattern) + int'(err_anode);
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL single_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_frame();
    int fv_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      an = 4'(~(4'b0001 << d));
      cathode = PATS[d + 1];
      repeat (8) begin
        tick();
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL frame_model: got %h want %h", obs, expv);
        end
        fv_cnt += int'(frame_valid);
      end
    end
    vectors++;
    if (fv_cnt !== 1) begin
      miscompares++;
      $display("FAIL frame_pulses: got %0d want 1", fv_cnt);
    end
    vectors++;
    if (digits !== 16'h4321 || digit_seen !== 4'b0000) begin
      miscompares++;
      $display("FAIL frame_digits: got %h/%b want 4321/0000", digits, digit_seen);
    end
  endtask

  task automatic test_glitch();
    int events = 0;
    an = 4'b1110;
    for (int p = 0; p < 10; p++) begin
      cathode = p[0] ? PATS[6] : PATS[5];
      repeat (S - 1) begin
        tick();
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL glitch_model: got %h want %h", obs, expv);
        end
        events += int'(frame_valid) + int'(err_pattern) + int'(err_anode) + int'(digit_seen != 4'b0000);
      end
    end
    vectors++;
    if (events !== 0) begin
      miscompares++;
      $display("FAIL glitch_reject: got %0d events want 0", events);
    end
    cathode = PATS[7];
    repeat (S) begin
      tick();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL glitch_hold_model: got %h want %h", obs, expv);
      end
    end
    an = 4'hF;
    cathode = 7'h7F;
    repeat (S) begin
      tick();
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL glitch_tail_model: got %h want %h", obs, expv);
      end
    end
    vectors++;
    if (digit_seen !== 4'b0001) begin
      miscompares++;
      $display("FAIL glitch_capture: got %b want 0001", digit_seen);
    end
  endtask

  task automatic test_illegal();
    int ep_cnt = 0;
    int ea_cnt = 0;
    logic [3:0]  seq_an  [5] = '{4'b1011, 4'b1100, 4'b1111, 4'b1101, 4'b0111};
    logic [6:0]  seq_cat [5];
    int          seq_len [5] = '{S + 2, 10, 10, S + 2, S + 2};
    seq_cat = '{7'b0101010, PATS[3], PATS[8], PATS[9], PATS[0]};
    for (int s = 0; s < 5; s++) begin
      an = seq_an[s];
      cathode = seq_cat[s];
      repeat (seq_len[s]) begin
        tick();
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL illegal_model s=%0d: got %h want %h", s, obs, expv);
        end
        ep_cnt += int'(err_pattern);
        ea_cnt += int'(err_anode);
      end
      if (s == 2) begin
        vectors++;
        if (ep_cnt !== 1 || ea_cnt !== 1 || digit_seen !== 4'b0101) begin
          miscompares++;
          $display("FAIL illegal_flags: got ep=%0d ea=%0d seen=%b want 1 1 0101", ep_cnt, ea_cnt, digit_seen);
        end
      end
    end
    vectors++;
    if (digits !== 16'h0E97 || digit_seen !== 4'b0000) begin
      miscompares++;
      $display("FAIL illegal_frame: got %h/%b want 0e97/0000", digits, digit_seen);
    end
  endtask

  task automatic test_blank_reset();
    logic [6:0] cats [7];
    cats = '{7'h7F, PATS[1], PATS[2], PATS[3], PATS[4], PATS[5], PATS[6]};
    for (int s = 0; s < 7; s++) begin
      an = 4'(~(4'b0001 << (s % 4)));
      cathode = cats[s];
      repeat (S + 2) begin
        tick();
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL blank_model s=%0d: got %h want %h", s, obs, expv);
        end
      end
      if (s == 3) begin
        vectors++;
        if (digits !== 16'h321F) begin
          miscompares++;
          $display("FAIL blank_frame: got %h want 321f", digits);
        end
      end
    end
    vectors++;
    if (digit_seen !== 4'b0111) begin
      miscompares++;
      $display("FAIL blank_partial: got %b want 0111", digit_seen);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if (digit_seen !== 4'b0000 || digits !== 16'h0000) begin
      miscompares++;
      $display("FAIL midframe_reset: got %h/%b want 0000/0000", digits, digit_seen);
    end
    rst_n = 1'b1;
    an = 4'hF;
    cathode = 7'h7F;
  endtask

  task automatic test_random();
    int r;
    int len;
    for (int seg = 0; seg < 600; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 7) an = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else if (r == 7) an = 4'hF;
      else an = 4'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0) cathode = 7'($urandom);
      else if (r == 1) cathode = 7'h7F;
      else cathode = PATS[$urandom_range(0, 9)];
      rst_n = ($urandom_range(0, 80) != 0);
      len = rst_n ? $urandom_range(1, S + 4) : 1;
      repeat (len) begin
        tick();
        vectors++;
        if (obs !== expv) begin
          miscompares++;
          $display("FAIL random_model seg=%0d: got %h want %h", seg, obs, expv);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_frame();
    test_glitch();
    test_illegal();
    test_blank_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
